// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry helpers for the data cache controller
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 32;

    // Index width for a given line count (line count is a power of two)
    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag width is whatever remains of the byte address above index and offset
    function automatic int tag_w(input int num_lines);
        return ADDR_W - OFFSET_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - tag/valid/dirty/data storage with one read port and one line-or-word write port
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256,
    parameter int IDX_W     = idx_w(NUM_LINES),
    parameter int TAG_W     = tag_w(NUM_LINES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [LINE_W-1:0]     line_data,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0]     word_data
);

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

    // Status bits: a refill makes a line valid and clean, a merged store makes it dirty
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Payload arrays are not reset; the valid bits make their contents irrelevant
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][word_sel*WORD_W +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int LINE_W    = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int IDX_W   = idx_w(NUM_LINES);
    localparam int TAG_W   = tag_w(NUM_LINES);
    localparam int TAG_LSB = OFFSET_W + IDX_W;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      req_tag, miss_tag_q, rd_tag;
    logic [IDX_W-1:0]      req_idx, miss_idx_q, sram_idx;
    logic [WORD_SEL_W-1:0] req_word;
    logic [LINE_W-1:0]     rd_line;
    logic                  rd_valid, rd_dirty;
    logic                  req, in_idle, hit, miss, line_we, word_we;
    logic                  unused_addr_lsbs;

    assign req_tag          = p1_addr_i[31:TAG_LSB];
    assign req_idx          = p1_addr_i[TAG_LSB-1:OFFSET_W];
    assign req_word         = p1_addr_i[OFFSET_W-1:2];
    assign unused_addr_lsbs = ^p1_addr_i[1:0];

    // Once a miss is in flight the array is addressed by the latched miss, not the live request
    assign in_idle  = (state_q == IDLE);
    assign sram_idx = in_idle ? req_idx : miss_idx_q;

    assign req  = p1_MemRead_i | p1_MemWrite_i;
    assign hit  = in_idle & req & rd_valid & (rd_tag == req_tag);
    assign miss = in_idle & req & ~hit;

    // A simultaneous read and write is a store, so only a pure load drives read data
    assign p1_data_o  = (hit & ~p1_MemWrite_i) ? rd_line[req_word*WORD_W +: WORD_W] : '0;
    assign p1_stall_o = ~in_idle | miss;

    assign line_we = (state_q == REFILL) & mem_ack_i;
    assign word_we = hit & p1_MemWrite_i;

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (sram_idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .line_we   (line_we),
        .line_tag  (miss_tag_q),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_sel  (req_word),
        .word_data (p1_data_i)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the missing line so a request that moves mid-miss cannot redirect the fill
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else if (miss) begin
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
        end
    end

    // Next-state: evict a dirty victim first, then refill, then retry the request in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (miss) state_d = (rd_valid & rd_dirty) ? WRITEBACK : REFILL;
            WRITEBACK: if (mem_ack_i) state_d = REFILL;
            REFILL:    if (mem_ack_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory-side outputs decoded from state and latched miss only
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        unique case (state_q)
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, miss_idx_q, {OFFSET_W{1'b0}}};
                mem_data_o   = rd_line;
            end
            REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller
module tb_dcache_controller;

    localparam int NL = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  addr = '0, wdata = '0;
    logic         mrd = 1'b0, mwr = 1'b0;
    logic [31:0]  rdata, maddr;
    logic         stall, men, mwe;
    logic [255:0] mdata_o;
    logic [255:0] mdata_i = '0;
    logic         resp_ack = 1'b0, spur_ack = 1'b0, mack;

    assign mack = resp_ack | spur_ack;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .p1_addr_i     (addr),
        .p1_data_i     (wdata),
        .p1_MemRead_i  (mrd),
        .p1_MemWrite_i (mwr),
        .p1_data_o     (rdata),
        .p1_stall_o    (stall),
        .mem_addr_o    (maddr),
        .mem_data_o    (mdata_o),
        .mem_enable_o  (men),
        .mem_write_o   (mwe),
        .mem_data_i    (mdata_i),
        .mem_ack_i     (mack)
    );

    // kind: 0 load done, 1 store done, 2 write-back, 3 refill
    typedef struct {
        int           kind;
        logic [31:0]  addr;
        logic [255:0] data;
    } item_t;

    item_t        exp_q[$];
    int           total = 0;
    int           bad = 0;
    logic [255:0] bm [int];
    logic [255:0] gl [int];
    bit           mvalid [NL];
    bit           mdirty [NL];
    int           mtag [NL];
    bit           mon_en = 1'b0;
    int           lat = 3;

    function automatic logic [255:0] init_line(input int la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = (32'(la) * 32'h9E37_79B9) ^ (32'(w) << 24) ^ 32'h5A5A_0001;
        return l;
    endfunction

    function automatic logic [255:0] get_bm(input int la);
        return bm.exists(la) ? bm[la] : init_line(la);
    endfunction

    function automatic logic [255:0] get_gl(input int la);
        return gl.exists(la) ? gl[la] : init_line(la);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_item(input int k, input logic [31:0] a, input logic [255:0] d);
        item_t it;
        it.kind = k;
        it.addr = a;
        it.data = d;
        exp_q.push_back(it);
    endtask

    // CPU-visible memory is a flat line map; the cache only decides which bus events occur
    task automatic predict(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d);
        int           idx, tag, la, w, vla;
        logic [255:0] line;
        idx = int'((a >> 5) % NL);
        tag = int'(a >> 9);
        la  = int'(a & ~32'd31);
        w   = int'((a >> 2) & 32'd7);
        if (!(mvalid[idx] && mtag[idx] == tag)) begin
            if (mvalid[idx] && mdirty[idx]) begin
                vla = (mtag[idx] << 9) | (idx << 5);
                push_item(2, 32'(vla), get_gl(vla));
            end
            push_item(3, 32'(la), '0);
            mvalid[idx] = 1'b1;
            mtag[idx]   = tag;
            mdirty[idx] = 1'b0;
        end
        line = get_gl(la);
        if (wr) begin
            line[w*32 +: 32] = d;
            gl[la]           = line;
            mdirty[idx]      = 1'b1;
            push_item(1, a, '0);
        end else if (rd) begin
            push_item(0, a, {224'd0, line[w*32 +: 32]});
        end
    endtask

    // Unwritten dirty data is lost on reset; the CPU view falls back to what memory holds
    task automatic model_reset();
        int la;
        for (int i = 0; i < NL; i++) begin
            if (mvalid[i] && mdirty[i]) begin
                la     = (mtag[i] << 9) | (i << 5);
                gl[la] = get_bm(la);
            end
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                         output int stalls);
        predict(a, rd, wr, d);
        addr = a; mrd = rd; mwr = wr; wdata = d;
        stalls = 0;
        @(negedge clk);
        while (stall && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
        if (stall) begin
            total++; bad++;
            $display("FAIL op_timeout: stall high after %0d cycles, required low", stalls);
        end
        @(posedge clk); #1;
        mrd = 1'b0; mwr = 1'b0;
    endtask

    // Memory model: ack a held request after lat cycles, one-cycle pulse
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (resp_ack) begin
                resp_ack = 1'b0;
                cnt      = 0;
            end else if (men && rst_n) begin
                cnt++;
                if (cnt >= lat) begin
                    resp_ack = 1'b1;
                    if (mwe) bm[int'(maddr)] = mdata_o;
                    else     mdata_i = get_bm(int'(maddr));
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT completes a bus or CPU transaction
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (!(men && mwe)) check("mem_data_outside_wb", mdata_o, '0);
                if (!men) check("mem_addr_idle", {224'd0, maddr}, '0);
                if (men && mack) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_mem_event: got addr %h write %0d, required none", maddr, mwe);
                    end else begin
                        it = exp_q.pop_front();
                        check("mem_kind", 256'(mwe ? 2 : 3), 256'(it.kind));
                        check("mem_addr", {224'd0, maddr}, {224'd0, it.addr});
                        if (mwe && it.kind == 2) check("wb_line", mdata_o, it.data);
                    end
                end
                if ((mrd || mwr) && !stall) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_cpu_done: got addr %h, required none", addr);
                    end else begin
                        it = exp_q.pop_front();
                        check("cpu_kind", 256'(mwr ? 1 : 0), 256'(it.kind));
                        check("cpu_addr", {224'd0, addr}, {224'd0, it.addr});
                        check("cpu_rdata", {224'd0, rdata}, it.data);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           st;
        logic [255:0] l;
        logic [31:0]  a;
        int           k;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {255'd0, stall}, '0);
        check("rst_rdata", {224'd0, rdata}, '0);
        check("rst_men", {255'd0, men}, '0);
        check("rst_mwe", {255'd0, mwe}, '0);
        check("rst_maddr", {224'd0, maddr}, '0);
        check("rst_mdata", mdata_o, '0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Cold read with a 10-cycle memory
        l = init_line(32'h40);
        l[31:0] = 32'hDEAD_BEEF;
        bm[32'h40] = l;
        gl[32'h40] = l;
        lat = 10;
        do_op(32'h40, 1, 0, 0, st);
        check("cold_stall_cycles", 256'(st), 256'd11);
        lat = 3;

        // Store hit, then load hit
        do_op(32'h44, 0, 1, 32'h1234_5678, st);
        check("store_hit_stall", 256'(st), '0);
        do_op(32'h44, 1, 0, 0, st);
        check("load_hit_stall", 256'(st), '0);

        // Conflict load forces write-back of dirty 0x40
        do_op(32'h240, 1, 0, 0, st);

        // Store miss: clean refill then merge; read every word; evict to see the merged line
        do_op(32'h88, 0, 1, 32'hCAFE_F00D, st);
        for (int w = 0; w < 8; w++) do_op(32'h80 + 32'(w * 4), 1, 0, 0, st);
        do_op(32'h288, 1, 0, 0, st);

        // Spurious ack in IDLE is ignored
        spur_ack = 1'b1;
        @(negedge clk);
        check("spur_men", {255'd0, men}, '0);
        check("spur_stall", {255'd0, stall}, '0);
        @(posedge clk); #1;
        spur_ack = 1'b0;
        @(negedge clk);
        check("spur_men_after", {255'd0, men}, '0);
        @(posedge clk); #1;

        // Read and write together behave as a store
        do_op(32'h288, 1, 1, 32'hA5A5_5A5A, st);
        check("rdwr_hit_stall", 256'(st), '0);
        do_op(32'h288, 1, 0, 0, st);

        // Reset asserted during a refill
        mon_en = 1'b0;
        lat = 40;
        addr = 32'h300; mrd = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("refill_men", {255'd0, men}, 256'd1);
        check("refill_addr", {224'd0, maddr}, {224'd0, 32'h300});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_men", {255'd0, men}, '0);
        check("async_rst_stall", {255'd0, stall}, 256'd1);
        @(posedge clk); #1;
        mrd = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        exp_q.delete();
        lat = 3;
        mon_en = 1'b1;
        do_op(32'h40, 1, 0, 0, st);
        total++;
        if (st == 0) begin
            bad++;
            $display("FAIL post_reset_miss: got stall cycles %0d, required nonzero", st);
        end

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            a   = {21'd0, 2'(($urandom_range(0, 3))), 4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            lat = $urandom_range(1, 4);
            k   = $urandom_range(0, 9);
            if (k < 5)      do_op(a, 1, 0, 0, st);
            else if (k < 9) do_op(a, 0, 1, $urandom, st);
            else            do_op(a, 1, 1, $urandom, st);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        check("queue_drained", 256'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
